shank_fpmult_seq: RTL and testbench

SHANK_FPMULT_SEQ -- requirements
Module: shank_fpmult_seq

---
 rtl/shank_fpmult_seq.sv | 244 ++++++++++++++++++++++++
 tb/tb_shank_fpmult_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shank_fpmult_seq.sv
// Sequential IEEE-style floating-point multiplier behind a small word-addressed register slot.
// Define FPMULT_ROUND_EN for round-to-nearest-even; otherwise the product is truncated.
module shank_fpmult_seq #(
  parameter int EXP_W      = 8,
  parameter int FRAC_W     = 23,
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data
);

  localparam int W        = EXP_W + FRAC_W + 1;
  localparam int M        = FRAC_W + 1;
  localparam int P        = 2 * M;
  localparam int EW2      = EXP_W + 2;
  localparam int MULT_CYC = (M + RADIX_BITS - 1) / RADIX_BITS;
  localparam int CNT_W    = $clog2(MULT_CYC + 1);
  localparam logic signed [EW2-1:0] BIAS     = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] EXP_ONES = EW2'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MULT, S_NORM, S_PACK} state_e;
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_e;

  state_e                  state_q, state_d;
  special_e                sp_q, sp_d;
  logic [W-1:0]            opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic [P-1:0]            acc_q, acc_d, mcand_q, mcand_d;
  logic [M-1:0]            mplier_q, mplier_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [EW2-1:0]   exp_q, exp_d;
  logic                    sign_q, sign_d;
  logic                    done_q, done_d, ovf_q, ovf_d, unf_q, unf_d;
  logic                    inv_q, inv_d, zero_q, zero_d;

  logic                    busy, wr_en;
  logic                    a_sign, b_sign;
  logic [EXP_W-1:0]        a_exp, b_exp;
  logic [FRAC_W-1:0]       a_frac, b_frac;
  logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic signed [EW2-1:0]   exp_sum, exp_fin;
  logic [P-1:0]            addend;
  logic [FRAC_W-1:0]       frac_t, frac_fin;
  logic                    unused_in;

  assign unused_in = ^{read, wr_data};
  assign busy      = (state_q != S_IDLE);
  assign wr_en     = cs & write;

  assign a_sign = opa_q[W-1];
  assign b_sign = opb_q[W-1];
  assign a_exp  = opa_q[W-2:FRAC_W];
  assign b_exp  = opb_q[W-2:FRAC_W];
  assign a_frac = opa_q[FRAC_W-1:0];
  assign b_frac = opb_q[FRAC_W-1:0];

  // Exponent field of zero covers denormals too: both are treated as signed zero.
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (a_exp == '1) && (a_frac == '0);
  assign b_inf  = (b_exp == '1) && (b_frac == '0);
  assign a_nan  = (a_exp == '1) && (a_frac != '0);
  assign b_nan  = (b_exp == '1) && (b_frac != '0);

  assign exp_sum = EW2'(a_exp) + EW2'(b_exp) - BIAS;

  always_comb begin
    addend = '0;
    for (int unsigned i = 0; i < RADIX_BITS; i++) begin
      if (mplier_q[i]) addend = addend + (mcand_q << i);
    end
  end

  // After NORM the hidden bit sits at P-2; the stored fraction follows it.
  assign frac_t = acc_q[P-3 -: FRAC_W];

`ifdef FPMULT_ROUND_EN
  logic              guard_b, round_b, sticky_b, rnd_inc;
  logic [FRAC_W:0]   frac_inc;

  assign guard_b  = acc_q[M-2];
  assign round_b  = acc_q[M-3];
  assign sticky_b = |acc_q[M-4:0];
  assign rnd_inc  = guard_b & (round_b | sticky_b | frac_t[0]);
  assign frac_inc = {1'b0, frac_t} + {{FRAC_W{1'b0}}, rnd_inc};
  assign frac_fin = frac_inc[FRAC_W-1:0];
  assign exp_fin  = exp_q + {{(EW2-1){1'b0}}, frac_inc[FRAC_W]};
`else
  assign frac_fin = frac_t;
  assign exp_fin  = exp_q;
`endif

  always_comb begin
    state_d  = state_q;
    sp_d     = sp_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    inv_d    = inv_q;
    zero_d   = zero_q;

    if (wr_en && !busy) begin
      case (addr)
        5'd0: opa_d = wr_data[W-1:0];
        5'd1: opb_d = wr_data[W-1:0];
        5'd2: begin
          if (wr_data[0] || wr_data[1]) begin
            done_d = 1'b0;
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
            inv_d  = 1'b0;
            zero_d = 1'b0;
          end
          if (wr_data[0]) state_d = S_UNPACK;
        end
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: ;
      S_UNPACK: begin
        sign_d   = a_sign ^ b_sign;
        exp_d    = exp_sum;
        mcand_d  = P'({1'b1, a_frac});
        mplier_d = {1'b1, b_frac};
        acc_d    = '0;
        cnt_d    = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) sp_d = SP_NAN;
        else if (a_inf || b_inf)                                      sp_d = SP_INF;
        else if (a_zero || b_zero)                                    sp_d = SP_ZERO;
        else                                                          sp_d = SP_NONE;
        state_d = (sp_d == SP_NONE) ? S_MULT : S_PACK;
      end
      S_MULT: begin
        acc_d    = acc_q + addend;
        mcand_d  = mcand_q << RADIX_BITS;
        mplier_d = mplier_q >> RADIX_BITS;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MULT_CYC - 1)) state_d = S_NORM;
      end
      S_NORM: begin
        // The bit shifted out is folded into bit 0 so it still counts as sticky.
        if (acc_q[P-1]) begin
          acc_d = {1'b0, acc_q[P-1:2], acc_q[1] | acc_q[0]};
          exp_d = exp_q + EW2'(1);
        end
        state_d = S_PACK;
      end
      S_PACK: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        case (sp_q)
          SP_NAN: begin
            res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
            inv_d = 1'b1;
          end
          SP_INF:  res_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          SP_ZERO: begin
            res_d  = {sign_q, {(W-1){1'b0}}};
            zero_d = 1'b1;
          end
          default: begin
            if (exp_fin >= EXP_ONES) begin
              res_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
              ovf_d = 1'b1;
            end else if (exp_fin[EW2-1] || (exp_fin == '0)) begin
              res_d  = {sign_q, {(W-1){1'b0}}};
              unf_d  = 1'b1;
              zero_d = 1'b1;
            end else begin
              res_d = {sign_q, exp_fin[EXP_W-1:0], frac_fin};
            end
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sp_q     <= SP_NONE;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inv_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sp_q     <= sp_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inv_q    <= inv_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      5'd0: rd_data = 32'(opa_q);
      5'd1: rd_data = 32'(opb_q);
      5'd3: rd_data = {26'd0, zero_q, inv_q, unf_q, ovf_q, done_q, busy};
      5'd4: rd_data = 32'(res_q);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shank_fpmult_seq.sv
// Bench for shank_fpmult_seq: directed vector table, register-slot corner sequences,
// and random operands checked against an arithmetic reference model.
module tb_shank_fpmult_seq;

  logic        clk = 1'b0;
  logic        reset, cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data, rd_data;

  int checks = 0;
  int errors = 0;

  shank_fpmult_seq dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] st;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(posedge clk);
    #1;
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    addr = a; cs = 1'b1; read = 1'b1;
    #1;
    d = rd_data;
    cs = 1'b0; read = 1'b0;
  endtask

  // Counts edges until done is seen; returns 0 if the budget runs out.
  task automatic wait_done(output logic [31:0] st, output int n);
    n = 0;
    st = '0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk);
      #1;
      rd(5'd3, st);
      if (st[1]) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic [31:0] st, output int lat);
    wr(5'd0, a);
    wr(5'd1, b);
    wr(5'd2, 32'h1);
    wait_done(st, lat);
    rd(5'd4, res);
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic [31:0] st, output int lat);
    logic [7:0]      ea, eb;
    logic [22:0]     fa, fb;
    logic            sg, na, nb, ia, ib, za, zb;
    longint unsigned p, m, rem, half;
    int              e, sh;
    ea = a[30:23]; eb = b[30:23];
    fa = a[22:0];  fb = b[22:0];
    sg = a[31] ^ b[31];
    na = (ea == 8'hFF) && (fa != 0);
    nb = (eb == 8'hFF) && (fb != 0);
    ia = (ea == 8'hFF) && (fa == 0);
    ib = (eb == 8'hFF) && (fb == 0);
    za = (ea == 8'h00);
    zb = (eb == 8'h00);
    st = 32'h2;
    res = '0;
    if (na || nb || (ia && zb) || (za && ib)) begin
      res = 32'h7FC00000; st = st | 32'h10; lat = 2;
    end else if (ia || ib) begin
      res = {sg, 8'hFF, 23'h0}; lat = 2;
    end else if (za || zb) begin
      res = {sg, 31'h0}; st = st | 32'h20; lat = 2;
    end else begin
      lat = 27;
      p = 64'({1'b1, fa}) * 64'({1'b1, fb});
      e = int'(ea) + int'(eb) - 127;
      if (p >= (64'd1 << 47)) begin
        sh = 24; e++;
      end else begin
        sh = 23;
      end
      m    = p >> sh;
      rem  = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
`ifdef FPMULT_ROUND_EN
      if (rem > half || (rem == half && m[0])) m++;
      if (m == (64'd1 << 24)) begin
        m = m >> 1; e++;
      end
`else
      if (rem > half) m = m;
`endif
      if (e >= 255) begin
        res = {sg, 8'hFF, 23'h0}; st = st | 32'h4;
      end else if (e <= 0) begin
        res = {sg, 31'h0}; st = st | 32'h28;
      end else begin
        res = {sg, e[7:0], m[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] gen_operand();
    logic [7:0]  ex;
    logic [22:0] fr;
    int unsigned sel;
    sel = $urandom_range(0, 9);
    fr  = 23'($urandom);
    if ($urandom_range(0, 5) == 0) fr = '0;
    case (sel)
      0:       ex = 8'h00;
      1:       ex = 8'hFF;
      2:       ex = 8'($urandom_range(200, 254));
      3:       ex = 8'($urandom_range(1, 40));
      default: ex = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), ex, fr};
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, s, er, es;
    int          lat, elat, n;

    vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 32'h02, 27};
    vecs[1]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 32'h06, 27};
    vecs[2]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 32'h12, 2};
    vecs[3]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h12, 2};
`ifdef FPMULT_ROUND_EN
    vecs[4]  = '{32'h3FC00001, 32'h40000001, 32'h40400003, 32'h02, 27};
`else
    vecs[4]  = '{32'h3FC00001, 32'h40000001, 32'h40400002, 32'h02, 27};
`endif
    vecs[5]  = '{32'h00800000, 32'h00800000, 32'h00000000, 32'h2A, 27};
    vecs[6]  = '{32'h80000000, 32'h40000000, 32'h80000000, 32'h22, 2};
    vecs[7]  = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 32'h02, 2};
    vecs[8]  = '{32'h00400000, 32'hC0000000, 32'h80000000, 32'h22, 2};
    vecs[9]  = '{32'hC0400000, 32'hC0000000, 32'h40C00000, 32'h02, 27};
    vecs[10] = '{32'h3F800000, 32'h7FC00001, 32'h7FC00000, 32'h12, 2};
    vecs[11] = '{32'hBF800000, 32'h3F800000, 32'hBF800000, 32'h02, 27};

    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      rd(5'(i), r);
      check($sformatf("reset_rd%0d", i), r, 32'h0);
    end

    wr(5'd0, 32'h12345678);
    wr(5'd1, 32'h9ABCDEF0);
    rd(5'd0, r); check("opa_readback", r, 32'h12345678);
    rd(5'd1, r); check("opb_readback", r, 32'h9ABCDEF0);
    rd(5'd2, r); check("ctrl_reads0", r, 32'h0);
    rd(5'd7, r); check("addr7_reads0", r, 32'h0);

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, r, s, lat);
      check($sformatf("vec%0d_res", i), r, vecs[i].res);
      check($sformatf("vec%0d_status", i), s, vecs[i].st);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Busy: operand writes, restart and clear-flags are all ignored; RESULT keeps the old value.
    wr(5'd0, 32'h3FC00000);
    wr(5'd1, 32'h40000000);
    wr(5'd2, 32'h1);
    wr(5'd0, 32'hDEADBEEF);
    wr(5'd1, 32'h00000000);
    wr(5'd2, 32'h2);
    wr(5'd2, 32'h1);
    rd(5'd0, r); check("busy_opa_kept", r, 32'h3FC00000);
    rd(5'd1, r); check("busy_opb_kept", r, 32'h40000000);
    rd(5'd3, r); check("busy_status", r, 32'h1);
    rd(5'd4, r); check("busy_prev_result", r, 32'hBF800000);
    wait_done(s, n);
    check("busy_total_latency", 32'(n + 4), 32'd27);
    rd(5'd4, r); check("busy_final_result", r, 32'h40400000);
    check("busy_final_status", s, 32'h2);

    // Clear flags, then start+clear together: start wins.
    do_op(32'h7F000000, 32'h7F000000, r, s, lat);
    check("ovf_status", s, 32'h6);
    wr(5'd2, 32'h2);
    rd(5'd3, r); check("clear_flags", r, 32'h0);
    rd(5'd4, r); check("clear_keeps_result", r, 32'h7F800000);
    wr(5'd2, 32'h3);
    rd(5'd3, r); check("start_wins_busy", r, 32'h1);
    wait_done(s, n);
    check("start_wins_latency", 32'(n), 32'd27);
    check("start_wins_status", s, 32'h6);

    // Reset 10 cycles into MULT with a concurrent OPB write.
    wr(5'd0, 32'h3FC00000);
    wr(5'd1, 32'h40000000);
    wr(5'd2, 32'h1);
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; cs = 1'b1; write = 1'b1; addr = 5'd1; wr_data = 32'h40000000;
    @(posedge clk);
    #1;
    reset = 1'b0; cs = 1'b0; write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd(5'(i), r);
      check($sformatf("midreset_rd%0d", i), r, 32'h0);
    end
    repeat (30) @(posedge clk);
    #1;
    rd(5'd3, r); check("midreset_status_later", r, 32'h0);
    rd(5'd4, r); check("midreset_result_later", r, 32'h0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = gen_operand();
      b = gen_operand();
      model(a, b, er, es, elat);
      do_op(a, b, r, s, lat);
      check($sformatf("rnd%0d_res a=%h b=%h", i, a, b), r, er);
      check($sformatf("rnd%0d_status", i), s, es);
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(elat));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
